imem_fetch_unit: RTL
====================

# imem_fetch_unit

Parametrised, writable instruction memory with a registered fetch handshake, for the CPU fetch stage. It clears its array with a one-word-per-cycle sequencer after reset and accepts program loads through a word-indexed write port. It returns one instruction per accepted byte-addressed fetch, with misalignment and out-of-range errors and a stall-tolerant output register.

## Interface
Parameters:
- DATA_W, 32, instruction word width in bits
- DEPTH, 128, number of words; must be a power of two, at least 4
- ADDR_W, 32, fetch byte-address width
- IDX_W, $clog2(DEPTH), word index width (derived; do not override)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- busy  out  1  high while the clear sequencer runs
- ld_en  in  1  load strobe; one word per cycle
- ld_idx  in  IDX_W  word index to write
- ld_data  in  DATA_W  word to write
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address of the fetch
- fetch_ready  in  1  consumer accepts the current output
- fetch_valid  out  1  instruction, fetch_err hold a result
- instruction  out  DATA_W  fetched word
- fetch_err  out  1  result is misaligned or out of range

## Operation
- States: CLEAR and READY.
  - reset low puts the block in CLEAR with clr_idx=0.
  - In CLEAR, mem[clr_idx] is written to 0 each cycle and clr_idx increments.
  - When clr_idx = DEPTH-1 is written, the state moves to READY.
- busy = (state==CLEAR).
- Reset values: busy=1, fetch_valid=0, instruction=0, fetch_err=0, clr_idx=0.
- ld_en is ignored in CLEAR. In READY, ld_en writes mem[ld_idx] = ld_data.
- Fetch acceptance: accept = fetch_req & ~busy & (~fetch_valid | fetch_ready). A request that is not accepted is dropped; the requester holds fetch_req.
- On accept, word index w = fetch_addr >> 2.
  - Error when fetch_addr[1:0] != 0 or w >= DEPTH. The comparison uses the full ADDR_W-2 bits, with no truncation before compare.
  - On error: instruction = 0, fetch_err = 1.
  - Otherwise: instruction = mem[w], fetch_err = 0.
- Write-first: if ld_en is set in the same cycle and ld_idx == w on an accepted, non-error fetch, instruction = ld_data.
- Output register updates:
  - On accept, fetch_valid = 1.
  - Otherwise, when fetch_ready = 1, fetch_valid = 0.
  - Otherwise, fetch_valid, instruction and fetch_err hold unchanged.
- A zero word is a legal instruction. It is returned as 0 with fetch_err = 0, never X.
- reset low mid-operation (during CLEAR, a stall, or a load) discards everything. State, outputs and clr_idx return to reset values on that edge, and the array is re-cleared.

## Timing
- Clear takes DEPTH cycles after the first rising edge with reset high. busy falls on the edge that writes the last word.
- Fetch latency is 1 cycle: request accepted at edge N, result valid after edge N.
- Throughput is 1 fetch per cycle while fetch_ready = 1. Back-to-back accepts replace the output each cycle.
- Stall: with fetch_valid = 1 and fetch_ready = 0, no accept occurs and the outputs are stable.
- Load write is visible to a fetch in the same cycle (bypass) and to all later cycles.
- Simultaneous CLEAR and ld_en: the load is lost.
- Simultaneous fetch and load to a different index: both complete.

## Configuration
- Macro: IMEM_BOOT_PROGRAM_EN.
- Defined: on the CLEAR→READY transition edge, words 0..3 are written as 32'h00011020, 32'h00642820, 32'hae010000 and 32'h8e040000, zero-extended or truncated to DATA_W. Words 4..DEPTH-1 stay 0.
- Undefined: the array holds all zeros after clear, and a program must be loaded through ld_en.
- Transition timing and busy are identical in both builds.

## Test plan
- Clear timing: hold reset low 3 cycles, then release. Required: busy stays 1 for exactly 128 edges, then 0. fetch_addr=0x0 then returns 0 with fetch_err=0 when IMEM_BOOT_PROGRAM_EN is undefined, or 0x00011020 when it is defined.
- Load then fetch: load idx 5 = 0xDEADBEEF, then fetch 0x14. Required: one cycle later fetch_valid=1 and instruction=0xDEADBEEF.
- Errors: fetch 0x6 gives fetch_err=1 and instruction=0. Fetch 0x200 gives fetch_err=1. Fetch 0x1FC gives fetch_err=0.
- Stall: with fetch_ready=0, fetch 0x0 then request 0x4. Required: the output holds word 0 and the second request is not accepted. Raise fetch_ready: word 1 appears on the next cycle.
- Write-first: in the same cycle, load idx 2 = 0x12345678 and fetch 0x8. Required: instruction=0x12345678.
- Reset mid-stream: drive reset low during back-to-back fetches. Required: next edge gives fetch_valid=0, busy=1, and the previously loaded words read 0 after the re-clear.

Source files
------------

// File: rtl/imem_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_fetch_unit_if                                                         |
// | Load port and fetch handshake bundle for the writable instruction memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface imem_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic              busy;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_err;

  // Requester side: drives loads and fetches, consumes results.
  modport master (
    input  busy, fetch_valid, instruction, fetch_err,
    output ld_en, ld_idx, ld_data, fetch_req, fetch_addr, fetch_ready
  );

  // Memory side.
  modport slave (
    output busy, fetch_valid, instruction, fetch_err,
    input  ld_en, ld_idx, ld_data, fetch_req, fetch_addr, fetch_ready
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_fetch_unit                                                            |
// | Writable instruction memory: post-reset clear sequencer, word load port,   |
// | registered byte-addressed fetch with error flag and stall-tolerant output. |
// | Optional build macro IMEM_BOOT_PROGRAM_EN preloads a 4-word boot program.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_fetch_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  imem_fetch_unit_if.slave       bus
);

  localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-3:0] c_depth_w  = (ADDR_W-2)'(DEPTH);
`ifdef IMEM_BOOT_PROGRAM_EN
  localparam logic [DATA_W-1:0] c_boot0 = DATA_W'(32'h00011020);
  localparam logic [DATA_W-1:0] c_boot1 = DATA_W'(32'h00642820);
  localparam logic [DATA_W-1:0] c_boot2 = DATA_W'(32'hae010000);
  localparam logic [DATA_W-1:0] c_boot3 = DATA_W'(32'h8e040000);
`endif

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_idx;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_accept;
  logic [ADDR_W-3:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_bypass;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy   = (r_state == ST_CLEAR);
  assign w_accept = bus.fetch_req & ~w_busy & (~r_valid | bus.fetch_ready);

  // Range check uses the whole word address so high address bits never alias.
  assign w_word   = bus.fetch_addr[ADDR_W-1:2];
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_err    = (bus.fetch_addr[1:0] != 2'b00) | (w_word >= c_depth_w);
  assign w_bypass = bus.ld_en & ~w_busy & (bus.ld_idx == w_idx);
  assign w_rdata  = w_bypass ? bus.ld_data : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (r_clr_idx == c_last_idx) begin
          r_state <= ST_READY;
        end
      end

      if (w_accept) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_instr <= w_err ? '0 : w_rdata;
      end else if (bus.fetch_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Array has no reset of its own; the sequencer rewrites every word after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
`ifdef IMEM_BOOT_PROGRAM_EN
        // Placed after the clear write so word DEPTH-1 keeps its boot value when DEPTH is 4.
        if (r_clr_idx == c_last_idx) begin
          r_mem[0] <= c_boot0;
          r_mem[1] <= c_boot1;
          r_mem[2] <= c_boot2;
          r_mem[3] <= c_boot3;
        end
`endif
      end else if (bus.ld_en) begin
        r_mem[bus.ld_idx] <= bus.ld_data;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.fetch_valid = r_valid;
  assign bus.instruction = r_instr;
  assign bus.fetch_err   = r_err;

endmodule
`default_nettype wire
